// File: rtl/spi_frame_loader_if.sv
// -----------------------------------------------------------------------------
// spi_frame_loader_if
// Write port between the SPI frame loader and the SPRAM frame buffer
// controller.
//   addressWrite [18:0] : pixel address of the current/last write
//   writeData    [1:0]  : pixel value of the current/last write
//   load                : one-cycle write strobe
//   frameDone           : one-cycle pulse after the last pixel of a frame
// master = loader (drives the port), slave = frame buffer controller.
// -----------------------------------------------------------------------------
interface spi_frame_loader_if;
   logic [18:0] addressWrite;
   logic [1:0]  writeData;
   logic        load;
   logic        frameDone;

   modport master (output addressWrite, writeData, load, frameDone);
   modport slave  (input  addressWrite, writeData, load, frameDone);
endinterface

// File: rtl/spi_frame_loader.sv
// -----------------------------------------------------------------------------
// spi_frame_loader
// Deserializes a 2-bit-per-pixel stream from an SPI master (mode 0, MSB first,
// four pixels per byte) in the mainClk domain and writes each pixel into the
// frame buffer controller with strobes exactly LOAD_GAP cycles apart.
//   mainClk   : system clock
//   nreset    : asynchronous active-low reset
//   sck       : SPI clock (asynchronous, <= mainClk/8)
//   cs_n      : SPI chip select, falling edge starts a new frame
//   mosi      : SPI data
//   wr        : frame buffer write port (master side)
//   overflow  : sticky, set when a received byte had to be dropped
//   busy      : a byte is buffered or being emitted
// -----------------------------------------------------------------------------
module spi_frame_loader #(
   parameter int FRAME_PIXELS = 307200,
   parameter int LOAD_GAP     = 4
) (
   input  logic                mainClk,
   input  logic                nreset,
   input  logic                sck,
   input  logic                cs_n,
   input  logic                mosi,
   spi_frame_loader_if.master  wr,
   output logic                overflow,
   output logic                busy
);

   localparam int              GAP_W    = (LOAD_GAP > 2) ? $clog2(LOAD_GAP) : 2;
   localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(LOAD_GAP - 1);
   localparam logic [18:0]     LAST_PIX = 19'(FRAME_PIXELS - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GAP} state_t;

   // ---------------------------------------------------------------- input sync
   logic [1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
   logic       r_sck_d, r_cs_d;

   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours regardless of statement order.
   always_ff @(posedge mainClk or negedge nreset) begin
      if (!nreset) begin
         r_sck_sync  <= 2'b00;
         r_cs_sync   <= 2'b11;
         r_mosi_sync <= 2'b00;
         r_sck_d     <= 1'b0;
         r_cs_d      <= 1'b1;
      end else begin
         r_sck_sync  <= {r_sck_sync[0], sck};
         r_cs_sync   <= {r_cs_sync[0], cs_n};
         r_mosi_sync <= {r_mosi_sync[0], mosi};
         r_sck_d     <= r_sck_sync[1];
         r_cs_d      <= r_cs_sync[1];
      end
   end

   logic w_sck_rise, w_cs_fall, w_cs_rise, w_cs_active;
   assign w_sck_rise  = r_sck_sync[1] & ~r_sck_d;
   assign w_cs_fall   = ~r_cs_sync[1] & r_cs_d;
   assign w_cs_rise   = r_cs_sync[1] & ~r_cs_d;
   assign w_cs_active = ~r_cs_sync[1];

   // ------------------------------------------------------------ shift register
   logic [2:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic       w_byte_done;
   logic [7:0] w_byte;

   // A chip-select fall in the same cycle as the 8th bit discards that byte.
   assign w_byte_done = w_cs_active & w_sck_rise & (r_bit_cnt == 3'd7) & ~w_cs_fall;
   assign w_byte      = {r_shift[6:0], r_mosi_sync[1]};

   always_ff @(posedge mainClk or negedge nreset) begin
      if (!nreset) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else if (w_cs_fall || w_cs_rise) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else if (w_cs_active && w_sck_rise) begin
         r_bit_cnt <= r_bit_cnt + 3'd1;
         r_shift   <= w_byte;
      end
   end

   // ---------------------------------------------------------- 2-entry byte FIFO
   logic [7:0] r_fifo [2];
   logic       r_wr_ptr, r_rd_ptr;
   logic [1:0] r_count;
   logic       w_pop, w_push, w_drop;

   // A pop frees the head slot in the same cycle, so a full FIFO can accept.
   assign w_push = w_byte_done & ((r_count != 2'd2) | w_pop);
   assign w_drop = w_byte_done & (r_count == 2'd2) & ~w_pop;

   // NOTE: the byte storage has no reset; occupancy and pointers alone decide
   // what is valid, so the data flops stay plain enables.
   always_ff @(posedge mainClk) begin
      if (w_push) r_fifo[r_wr_ptr] <= w_byte;
   end

   always_ff @(posedge mainClk or negedge nreset) begin
      if (!nreset) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= '0;
      end else if (w_cs_fall) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   // Survives chip-select framing; only reset clears it.
   always_ff @(posedge mainClk or negedge nreset) begin
      if (!nreset)     overflow <= 1'b0;
      else if (w_drop) overflow <= 1'b1;
   end

   // ------------------------------------------------------------------- emitter
   state_t           r_state;
   logic [1:0]       r_pix_idx;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [18:0]      r_pix_cnt;

   logic w_gap_end, w_go_first, w_go_next_pix, w_go_next_byte, w_enter_load;
   logic [1:0] w_load_data;

   function automatic logic [1:0] pick(input logic [7:0] b, input logic [1:0] idx);
      case (idx)
         2'd0:    return b[7:6];
         2'd1:    return b[5:4];
         2'd2:    return b[3:2];
         default: return b[1:0];
      endcase
   endfunction

   assign w_gap_end      = (r_state == S_GAP) & (r_gap_cnt == GAP_W'(1));
   assign w_pop          = w_gap_end & (r_pix_idx == 2'd3) & ~w_cs_fall;
   assign w_go_first     = (r_state == S_IDLE) & (r_count != 2'd0);
   assign w_go_next_pix  = w_gap_end & (r_pix_idx != 2'd3);
   // Continue straight into the next byte only if it was already stored, so
   // strobe spacing stays uniform across byte boundaries.
   assign w_go_next_byte = w_pop & (r_count == 2'd2);
   assign w_enter_load   = (w_go_first | w_go_next_pix | w_go_next_byte) & ~w_cs_fall;

   // NOTE: every combinational output gets a default first so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      w_load_data = pick(r_fifo[~r_rd_ptr], 2'd0);
      if (w_go_first)         w_load_data = pick(r_fifo[r_rd_ptr], 2'd0);
      else if (w_go_next_pix) w_load_data = pick(r_fifo[r_rd_ptr], r_pix_idx + 2'd1);
   end

   always_ff @(posedge mainClk or negedge nreset) begin
      if (!nreset) begin
         r_state         <= S_IDLE;
         r_pix_idx       <= '0;
         r_gap_cnt       <= '0;
         r_pix_cnt       <= '0;
         wr.load         <= 1'b0;
         wr.frameDone    <= 1'b0;
         wr.addressWrite <= '0;
         wr.writeData    <= '0;
      end else begin
         wr.load      <= 1'b0;
         wr.frameDone <= 1'b0;
         if (w_cs_fall) begin
            r_state   <= S_IDLE;
            r_pix_idx <= '0;
            r_pix_cnt <= '0;
         end else if (w_enter_load) begin
            r_state         <= S_LOAD;
            r_pix_idx       <= w_go_next_pix ? r_pix_idx + 2'd1 : 2'd0;
            wr.load         <= 1'b1;
            wr.addressWrite <= r_pix_cnt;
            wr.writeData    <= w_load_data;
            r_pix_cnt       <= (r_pix_cnt == LAST_PIX) ? 19'd0 : r_pix_cnt + 19'd1;
         end else begin
            case (r_state)
               S_LOAD: begin
                  r_state      <= S_GAP;
                  r_gap_cnt    <= GAP_INIT;
                  wr.frameDone <= (wr.addressWrite == LAST_PIX);
               end
               S_GAP: begin
                  // Reaching the end of the gap here means the FIFO ran dry.
                  if (r_gap_cnt == GAP_W'(1)) r_state <= S_IDLE;
                  else                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign busy = (r_count != 2'd0) | (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_loader
// Two loaders share sck/mosi and have their own chip selects:
//   dut_a : default frame size, LOAD_GAP=4   (reset, single, back-to-back,
//           partial byte)
//   dut_b : FRAME_PIXELS=8, LOAD_GAP=64      (frame wrap, overflow). At 64
//           cycles per byte on the wire and 256 cycles to drain one, bytes 3
//           and 4 of a back-to-back burst find the FIFO full.
// Expected strobes are queued when a byte is driven and compared per strobe.
// -----------------------------------------------------------------------------
module tb_spi_frame_loader;

   localparam int FP_A  = 307200;
   localparam int GAP_A = 4;
   localparam int FP_B  = 8;
   localparam int GAP_B = 64;

   typedef struct {
      logic [18:0] addr;
      logic [1:0]  data;
      bit          contig;   // must follow the previous strobe by exactly LOAD_GAP
   } sb_t;

   logic mainClk = 1'b0;
   logic nreset  = 1'b0;
   logic sck     = 1'b0;
   logic mosi    = 1'b0;
   logic cs_n_a  = 1'b1;
   logic cs_n_b  = 1'b1;
   logic ovf_a, busy_a, ovf_b, busy_b;

   spi_frame_loader_if bus_a ();
   spi_frame_loader_if bus_b ();

   spi_frame_loader #(.FRAME_PIXELS(FP_A), .LOAD_GAP(GAP_A)) dut_a (
      .mainClk(mainClk), .nreset(nreset), .sck(sck), .cs_n(cs_n_a), .mosi(mosi),
      .wr(bus_a.master), .overflow(ovf_a), .busy(busy_a));

   spi_frame_loader #(.FRAME_PIXELS(FP_B), .LOAD_GAP(GAP_B)) dut_b (
      .mainClk(mainClk), .nreset(nreset), .sck(sck), .cs_n(cs_n_b), .mosi(mosi),
      .wr(bus_b.master), .overflow(ovf_b), .busy(busy_b));

   always #5 mainClk = ~mainClk;

   int  passed = 0, total = 0;
   int  cyc = 0;
   sb_t q_a[$], q_b[$];
   int  exp_addr_a = 0, exp_addr_b = 0;
   int  last_a = 0, last_b = 0;
   int  n_load_a = 0, n_load_b = 0, n_fd_b = 0;
   bit  prev_b_last = 0;

   always @(posedge mainClk) cyc++;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   // ------------------------------------------------------------ strobe monitors
   always @(negedge mainClk) begin : mon_a
      sb_t e;
      if (bus_a.load) begin
         n_load_a++;
         check("a_load_expected", 32'(q_a.size() != 0), 32'd1);
         if (q_a.size() != 0) begin
            e = q_a.pop_front();
            check("a_addr", 32'(bus_a.addressWrite), 32'(e.addr));
            check("a_data", 32'(bus_a.writeData), 32'(e.data));
            if (e.contig) check("a_spacing", 32'(cyc - last_a), 32'(GAP_A));
         end
         last_a = cyc;
      end
   end

   always @(negedge mainClk) begin : mon_b
      sb_t e;
      if (bus_b.frameDone || prev_b_last)
         check("b_frame_done", 32'(bus_b.frameDone), 32'(prev_b_last));
      if (bus_b.frameDone) n_fd_b++;
      prev_b_last = bus_b.load && (bus_b.addressWrite == 19'(FP_B - 1));
      if (bus_b.load) begin
         n_load_b++;
         check("b_load_expected", 32'(q_b.size() != 0), 32'd1);
         if (q_b.size() != 0) begin
            e = q_b.pop_front();
            check("b_addr", 32'(bus_b.addressWrite), 32'(e.addr));
            check("b_data", 32'(bus_b.writeData), 32'(e.data));
            if (e.contig) check("b_spacing", 32'(cyc - last_b), 32'(GAP_B));
         end
         last_b = cyc;
      end
   end

   // ------------------------------------------------------------------ stimulus
   task automatic expect_byte(input int id, input logic [7:0] b, input bit first_contig);
      for (int p = 0; p < 4; p++) begin
         sb_t e;
         e.data   = b[7 - 2*p -: 2];
         e.contig = (p != 0) || first_contig;
         if (id == 0) begin
            e.addr = 19'(exp_addr_a);
            exp_addr_a = (exp_addr_a + 1) % FP_A;
            q_a.push_back(e);
         end else begin
            e.addr = 19'(exp_addr_b);
            exp_addr_b = (exp_addr_b + 1) % FP_B;
            q_b.push_back(e);
         end
      end
   endtask

   // Mode 0: data changes while sck is low, sampled on the rise; sck = mainClk/8.
   task automatic spi_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         mosi = b[i];
         repeat (4) @(posedge mainClk);
         sck = 1'b1;
         repeat (4) @(posedge mainClk);
         sck = 1'b0;
      end
   endtask

   task automatic cs_low(input int id);
      if (id == 0) begin cs_n_a = 1'b0; exp_addr_a = 0; end
      else         begin cs_n_b = 1'b0; exp_addr_b = 0; end
      repeat (4) @(posedge mainClk);
   endtask

   task automatic cs_high(input int id);
      repeat (4) @(posedge mainClk);
      if (id == 0) cs_n_a = 1'b1;
      else         cs_n_b = 1'b1;
      repeat (4) @(posedge mainClk);
   endtask

   task automatic wait_drain(input int id, input int limit);
      int n = 0;
      while (((id == 0) ? q_a.size() : q_b.size()) != 0 && n < limit) begin
         @(posedge mainClk);
         n++;
      end
      check((id == 0) ? "a_drain" : "b_drain",
            32'((id == 0) ? q_a.size() : q_b.size()), 32'd0);
      // Trailing cycles let any unexpected extra strobe reach the monitor.
      repeat (((id == 0) ? GAP_A : GAP_B) + 100) @(posedge mainClk);
      @(negedge mainClk);
      check((id == 0) ? "a_busy_idle" : "b_busy_idle",
            32'((id == 0) ? busy_a : busy_b), 32'd0);
   endtask

   initial begin
      int n0;
      int n;

      // ---- reset state
      repeat (5) @(posedge mainClk);
      @(negedge mainClk);
      check("rst_a_load", 32'(bus_a.load), 32'd0);
      check("rst_a_addr", 32'(bus_a.addressWrite), 32'd0);
      check("rst_a_data", 32'(bus_a.writeData), 32'd0);
      check("rst_a_fd",   32'(bus_a.frameDone), 32'd0);
      check("rst_a_ovf",  32'(ovf_a), 32'd0);
      check("rst_a_busy", 32'(busy_a), 32'd0);
      check("rst_b_busy", 32'(busy_b), 32'd0);
      nreset = 1'b1;
      repeat (3) @(posedge mainClk);

      // ---- single byte: 0xE4 -> data 3,2,1,0 at addresses 0..3
      cs_low(0);
      expect_byte(0, 8'hE4, 1'b0);
      spi_bits(8'hE4, 8);
      repeat (2) @(posedge mainClk);
      @(negedge mainClk);
      check("single_busy", 32'(busy_a), 32'd1);
      cs_high(0);
      wait_drain(0, 200);

      // ---- back-to-back bytes 0x1B, 0xFF
      cs_low(0);
      expect_byte(0, 8'h1B, 1'b0);
      spi_bits(8'h1B, 8);
      expect_byte(0, 8'hFF, 1'b0);
      spi_bits(8'hFF, 8);
      cs_high(0);
      wait_drain(0, 300);
      check("b2b_ovf", 32'(ovf_a), 32'd0);

      // ---- partial byte discarded, next frame restarts at address 0
      cs_low(0);
      expect_byte(0, 8'hAA, 1'b0);
      spi_bits(8'hAA, 8);
      spi_bits(8'hF8, 5);
      cs_high(0);
      wait_drain(0, 300);
      cs_low(0);
      expect_byte(0, 8'h55, 1'b0);
      spi_bits(8'h55, 8);
      cs_high(0);
      wait_drain(0, 300);

      // ---- reset in the middle of an emission
      cs_low(0);
      expect_byte(0, 8'hE4, 1'b0);
      n0 = n_load_a;
      spi_bits(8'hE4, 8);
      cs_n_a = 1'b1;
      n = 0;
      while (n_load_a < n0 + 2 && n < 200) begin
         @(negedge mainClk);
         n++;
      end
      check("mid_two_loads", 32'(n_load_a - n0), 32'd2);
      #2 nreset = 1'b0;
      #1;
      check("mid_rst_load", 32'(bus_a.load), 32'd0);
      check("mid_rst_addr", 32'(bus_a.addressWrite), 32'd0);
      check("mid_rst_data", 32'(bus_a.writeData), 32'd0);
      check("mid_rst_busy", 32'(busy_a), 32'd0);
      q_a.delete();
      repeat (3) @(posedge mainClk);
      nreset = 1'b1;
      n0 = n_load_a;
      repeat (100) @(posedge mainClk);
      @(negedge mainClk);
      check("mid_no_load", 32'(n_load_a - n0), 32'd0);

      // ---- frame wrap on dut_b: 3 bytes -> addresses 0..7, 0..3
      // Bytes are spaced so each arrives while the previous still drains.
      cs_low(1);
      n_fd_b = 0;
      expect_byte(1, 8'h1B, 1'b0);
      spi_bits(8'h1B, 8);
      repeat (150) @(posedge mainClk);
      expect_byte(1, 8'hE4, 1'b1);
      spi_bits(8'hE4, 8);
      repeat (150) @(posedge mainClk);
      expect_byte(1, 8'h6C, 1'b1);
      spi_bits(8'h6C, 8);
      cs_high(1);
      wait_drain(1, 2000);
      check("wrap_fd_count", 32'(n_fd_b), 32'd1);
      check("wrap_ovf", 32'(ovf_b), 32'd0);

      // ---- overflow on dut_b: 4 bytes back-to-back, bytes 3 and 4 dropped
      cs_low(1);
      expect_byte(1, 8'h9C, 1'b0);
      expect_byte(1, 8'h27, 1'b1);
      spi_bits(8'h9C, 8);
      spi_bits(8'h27, 8);
      spi_bits(8'hD8, 8);
      spi_bits(8'hB1, 8);
      @(negedge mainClk);
      check("ovf_set", 32'(ovf_b), 32'd1);
      cs_high(1);
      wait_drain(1, 2000);
      check("ovf_sticky", 32'(ovf_b), 32'd1);
      check("ovf_a_clear", 32'(ovf_a), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
